store_buffer: RTL and testbench

- Posted-write FIFO between the store-formatting stage (byte enables plus lane-shifted data) and the data-memory port.
- Accepts one formatted store per cycle and returns ready immediately, so the pipeline does not wait on memory latency.
- Drains entries in order over a valid/ready request interface.
- Reports load-address hazards against pending stores and exposes an empty flag for fence/drain.

---
 rtl/store_buffer_pkg.sv | 30 +++
 rtl/store_buffer_addr_match.sv | 45 ++++
 rtl/store_buffer.sv | 171 +++++++++++++++++
 tb/tb_store_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : store_buffer_pkg
// Purpose : Shared types, widths and field offsets for the store buffer.
//           An entry is packed as {word_addr, bwe, wdata} with wdata in the
//           low bits, so the data and bwe offsets do not depend on ADDR_W.
// Ports   : (package - none)
// Revision: 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

  localparam int SB_DATA_W   = 32;
  localparam int SB_BWE_W    = 4;

  // Field offsets inside a packed entry.
  localparam int SB_DATA_LSB = 0;
  localparam int SB_BWE_LSB  = SB_DATA_LSB + SB_DATA_W;
  localparam int SB_ADDR_LSB = SB_BWE_LSB + SB_BWE_W;

  localparam logic [SB_BWE_W-1:0] BWE_NONE = 4'b0000;

  // Entry width for a given byte-address width (word address is addr_w-2).
  function automatic int sb_entry_w(input int addr_w);
    return (addr_w - 2) + SB_BWE_W + SB_DATA_W;
  endfunction

  localparam int SB_ENTRY_W = sb_entry_w(32);

endpackage : store_buffer_pkg
`default_nettype wire

// File: rtl/store_buffer_addr_match.sv
`default_nettype none
// ============================================================================
// Module  : store_buffer_addr_match
// Purpose : DEPTH-wide parallel word-address comparator. Flags a load hazard
//           when any valid buffered store, or the store entering this cycle,
//           targets the same word as the load. Byte enables are not compared
//           (conservative, word-granular match).
// Ports   : entry_valid_i  - per-entry valid bits
//           entry_waddr_i  - flattened per-entry word addresses
//           st_valid_i     - store stage presents a store
//           st_bwe_i       - byte enables of the entering store
//           st_waddr_i     - word address of the entering store
//           ld_waddr_i     - word address of the load in the load stage
//           hazard_o       - overlap detected
// Revision: 1.0 - initial release
// ============================================================================
module store_buffer_addr_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WA_W  = 30
) (
  input  logic [DEPTH-1:0]      entry_valid_i,
  input  logic [DEPTH*WA_W-1:0] entry_waddr_i,
  input  logic                  st_valid_i,
  input  logic [SB_BWE_W-1:0]   st_bwe_i,
  input  logic [WA_W-1:0]       st_waddr_i,
  input  logic [WA_W-1:0]       ld_waddr_i,
  output logic                  hazard_o
);

  logic [DEPTH-1:0] entry_hit;
  logic             st_hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign entry_hit[i] = entry_valid_i[i] &&
                          (entry_waddr_i[i*WA_W +: WA_W] == ld_waddr_i);
  end

  // A zero-bwe store is a no-op and therefore cannot create a hazard.
  assign st_hit   = st_valid_i && (st_bwe_i != BWE_NONE) && (st_waddr_i == ld_waddr_i);
  assign hazard_o = (|entry_hit) || st_hit;

endmodule : store_buffer_addr_match
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module  : store_buffer
// Purpose : Posted-write FIFO between the store-formatting stage and the
//           data-memory port. Accepts one store per cycle, drains in order
//           over valid/ready, flags load-address hazards and reports empty.
// Ports   : clk, reset_n          - clock, async active-low reset
//           st_valid/st_addr/st_bwe/st_wdata/st_ready - store input side
//           mem_req_valid/mem_req_ready/mem_req_addr/mem_req_bwe/
//           mem_req_wdata         - memory request side (head entry)
//           ld_addr, ld_hazard    - load hazard check
//           empty                 - no entries held
// Revision: 1.0 - initial release
// ============================================================================
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 st_valid,
  input  logic [ADDR_W-1:0]    st_addr,
  input  logic [SB_BWE_W-1:0]  st_bwe,
  input  logic [SB_DATA_W-1:0] st_wdata,
  output logic                 st_ready,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_W-1:0]    mem_req_addr,
  output logic [SB_BWE_W-1:0]  mem_req_bwe,
  output logic [SB_DATA_W-1:0] mem_req_wdata,
  input  logic [ADDR_W-1:0]    ld_addr,
  output logic                 ld_hazard,
  output logic                 empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int WA_W    = ADDR_W - 2;
  localparam int ENTRY_W = sb_entry_w(ADDR_W);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               enq;
  logic               deq;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] new_entry;

  // Address low bits carry no meaning at word granularity.
  logic               unused_addr_lsbs;
  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  // --------------------------------------------------------------------------
  // Handshakes. st_ready depends only on registered count, so there is no
  // combinational path from mem_req_ready to st_ready: a full buffer refuses
  // a store even in a cycle where the head drains.
  // --------------------------------------------------------------------------
  assign st_ready      = (count_q != FULL_CNT);
  assign mem_req_valid = (count_q != '0);
  assign empty         = (count_q == '0);

  assign enq = st_valid && st_ready && (st_bwe != BWE_NONE);
  assign deq = mem_req_valid && mem_req_ready;

  assign new_entry = {st_addr[ADDR_W-1:2], st_bwe, st_wdata};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;

    if (enq) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // wr_ptr and rd_ptr only coincide when empty (no dequeue) or full (no
    // enqueue), so the clear and the set never hit the same slot together.
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (enq) begin
      valid_d[wr_ptr_q] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Storage is reset too so no X can ever reach an output or the comparator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else if (enq) begin
      entry_q[wr_ptr_q] <= new_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Head presentation: payload is forced to zero while empty.
  // --------------------------------------------------------------------------
  assign head = entry_q[rd_ptr_q];

  assign mem_req_addr  = mem_req_valid ? {head[SB_ADDR_LSB +: WA_W], 2'b00} : '0;
  assign mem_req_bwe   = mem_req_valid ? head[SB_BWE_LSB +: SB_BWE_W]        : '0;
  assign mem_req_wdata = mem_req_valid ? head[SB_DATA_LSB +: SB_DATA_W]      : '0;

  // --------------------------------------------------------------------------
  // Load hazard detection
  // --------------------------------------------------------------------------
  logic [DEPTH*WA_W-1:0] entry_waddr;

  for (genvar i = 0; i < DEPTH; i++) begin : g_waddr
    assign entry_waddr[i*WA_W +: WA_W] = entry_q[i][SB_ADDR_LSB +: WA_W];
  end

  store_buffer_addr_match #(
    .DEPTH (DEPTH),
    .WA_W  (WA_W)
  ) u_addr_match (
    .entry_valid_i (valid_q),
    .entry_waddr_i (entry_waddr),
    .st_valid_i    (st_valid),
    .st_bwe_i      (st_bwe),
    .st_waddr_i    (st_addr[ADDR_W-1:2]),
    .ld_waddr_i    (ld_addr[ADDR_W-1:2]),
    .hazard_o      (ld_hazard)
  );

endmodule : store_buffer
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_store_buffer
// Purpose : Self-checking bench for store_buffer. A queue-based reference
//           model is compared against every output on each falling edge;
//           directed sequences add hand-computed literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [3:0]  st_bwe;
  logic [31:0] st_wdata;
  logic        st_ready;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_bwe;
  logic [31:0] mem_req_wdata;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        empty;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .st_bwe        (st_bwe),
    .st_wdata      (st_wdata),
    .st_ready      (st_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_bwe   (mem_req_bwe),
    .mem_req_wdata (mem_req_wdata),
    .ld_addr       (ld_addr),
    .ld_hazard     (ld_hazard),
    .empty         (empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: an in-order queue of pending stores.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [29:0] wa;
    logic [3:0]  bwe;
    logic [31:0] d;
  } st_t;

  st_t mq[$];
  bit  m_enq, m_deq;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
    end else begin
      m_deq = (mq.size() != 0) && mem_req_ready;
      m_enq = st_valid && (st_bwe != 4'b0) && (mq.size() < DEPTH);
      if (m_deq) void'(mq.pop_front());
      if (m_enq) mq.push_back('{wa: st_addr[31:2], bwe: st_bwe, d: st_wdata});
    end
  end

  // Every-cycle comparison of all outputs against the model.
  logic        e_hz;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_bwe;

  always @(negedge clk) begin
    e_hz = 1'b0;
    foreach (mq[i]) if (mq[i].wa == ld_addr[31:2]) e_hz = 1'b1;
    if (st_valid && (st_bwe != 4'b0) && (st_addr[31:2] == ld_addr[31:2])) e_hz = 1'b1;
    if (mq.size() != 0) begin
      e_addr = {mq[0].wa, 2'b00}; e_bwe = mq[0].bwe; e_wdata = mq[0].d;
    end else begin
      e_addr = '0; e_bwe = '0; e_wdata = '0;
    end
    chk("m_st_ready",  64'(st_ready),      64'(mq.size() != DEPTH));
    chk("m_valid",     64'(mem_req_valid), 64'(mq.size() != 0));
    chk("m_empty",     64'(empty),         64'(mq.size() == 0));
    chk("m_addr",      64'(mem_req_addr),  64'(e_addr));
    chk("m_bwe",       64'(mem_req_bwe),   64'(e_bwe));
    chk("m_wdata",     64'(mem_req_wdata), 64'(e_wdata));
    chk("m_ld_hazard", 64'(ld_hazard),     64'(e_hz));
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_bwe = b; st_wdata = d;
    step();
    st_valid = 1'b0; st_bwe = 4'b0;
  endtask

  task automatic drain(input int n);
    mem_req_ready = 1'b1;
    repeat (n) step();
    mem_req_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_bwe = '0; st_wdata = '0;
    mem_req_ready = 1'b0; ld_addr = '0;
    repeat (2) step();
    chk("rst_empty",    64'(empty),         64'd1);
    chk("rst_st_ready", 64'(st_ready),      64'd1);
    chk("rst_valid",    64'(mem_req_valid), 64'd0);
    chk("rst_hazard",   64'(ld_hazard),     64'd0);
    chk("rst_addr",     64'(mem_req_addr),  64'd0);
    reset_n = 1'b1;
    step();

    // Single store: 1-cycle latency, payload held while not accepted.
    st_valid = 1'b1; st_addr = 32'h1003; st_bwe = 4'b1000; st_wdata = 32'hAB00_0000;
    #1 chk("single_pre_valid", 64'(mem_req_valid), 64'd0);
    step();
    st_valid = 1'b0; st_bwe = 4'b0;
    for (int k = 0; k < 3; k++) begin
      chk("single_valid", 64'(mem_req_valid), 64'd1);
      chk("single_addr",  64'(mem_req_addr),  64'h1000);
      chk("single_bwe",   64'(mem_req_bwe),   64'h8);
      chk("single_wdata", 64'(mem_req_wdata), 64'hAB00_0000);
      step();
    end
    drain(1);
    chk("single_empty", 64'(empty), 64'd1);

    // Fill, refuse fifth, drain in order.
    for (int i = 0; i < 4; i++) put(32'(i * 4), 4'b1111, 32'hC0DE_0000 + 32'(i));
    chk("fill_st_ready", 64'(st_ready), 64'd0);
    put(32'h10, 4'b1111, 32'hDEAD_BEEF);
    chk("fill_model_size", 64'(mq.size()), 64'd4);
    mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_order_addr",  64'(mem_req_addr),  64'(i * 4));
      chk("fill_order_wdata", 64'(mem_req_wdata), 64'(32'hC0DE_0000 + 32'(i)));
      step();
    end
    mem_req_ready = 1'b0;
    chk("fill_drained", 64'(empty), 64'd1);

    // Zero-bwe store while full is a no-op.
    for (int i = 0; i < 4; i++) put(32'h40 + 32'(i * 4), 4'b0011, 32'(i));
    put(32'h80, 4'b0000, 32'h1234_5678);
    chk("zbwe_st_ready", 64'(st_ready),     64'd0);
    chk("zbwe_head",     64'(mem_req_addr), 64'h40);
    chk("zbwe_size",     64'(mq.size()),    64'd4);
    drain(4);

    // Simultaneous enqueue/dequeue at count=2 across several wraps.
    put(32'h100, 4'b0001, 32'h0);
    put(32'h104, 4'b0001, 32'h1);
    mem_req_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      st_valid = 1'b1; st_addr = 32'h108 + 32'(4 * k); st_bwe = 4'b0001; st_wdata = 32'(k + 2);
      chk("sim_head_addr", 64'(mem_req_addr), 64'(32'h100 + 32'(4 * k)));
      chk("sim_st_ready",  64'(st_ready),     64'd1);
      step();
      chk("sim_count", 64'(mq.size()), 64'd2);
    end
    st_valid = 1'b0; st_bwe = 4'b0;
    chk("sim_tail0", 64'(mem_req_addr), 64'h128);
    step();
    chk("sim_tail1", 64'(mem_req_addr), 64'h12C);
    step();
    mem_req_ready = 1'b0;
    chk("sim_empty", 64'(empty), 64'd1);

    // Hazards.
    put(32'h2004, 4'b0100, 32'h0055_0000);
    ld_addr = 32'h2006;
    #1 chk("hz_entry_hit", 64'(ld_hazard), 64'd1);
    ld_addr = 32'h2008;
    #1 chk("hz_entry_miss", 64'(ld_hazard), 64'd0);
    drain(1);
    st_valid = 1'b1; st_addr = 32'h3000; st_bwe = 4'b0001; ld_addr = 32'h3002;
    #1 chk("hz_enter_hit", 64'(ld_hazard), 64'd1);
    st_bwe = 4'b0000;
    #1 chk("hz_enter_zero_bwe", 64'(ld_hazard), 64'd0);
    step();
    st_valid = 1'b0; ld_addr = '0;
    chk("hz_no_enq", 64'(empty), 64'd1);

    // Reset mid-stream with 3 entries held.
    for (int i = 0; i < 3; i++) put(32'h500 + 32'(i * 4), 4'b1111, 32'(i));
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_empty",    64'(empty),         64'd1);
    chk("mrst_valid",    64'(mem_req_valid), 64'd0);
    chk("mrst_st_ready", 64'(st_ready),      64'd1);
    step();
    reset_n = 1'b1;
    put(32'h600, 4'b0010, 32'h0000_7700);
    chk("mrst_new_addr",  64'(mem_req_addr),  64'h600);
    chk("mrst_new_wdata", 64'(mem_req_wdata), 64'h7700);
    drain(1);
    chk("mrst_final_empty", 64'(empty), 64'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_store_buffer
`default_nettype wire
